// File: rtl/axi_mm_mem_responder_pkg.sv
// Shared AXI codes, FSM state types and request-check helpers for the memory responder.
package axi_mm_mem_responder_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {RdIdle, RdFetch, RdValid} rd_state_e;
  typedef enum logic [1:0] {WrIdle, WrData, WrResp} wr_state_e;

  // WRAP walks the address exactly like INCR; only FIXED (and reserved) hold it.
  function automatic logic burst_advances(logic [1:0] burst);
    return (burst == BURST_INCR) || (burst == BURST_WRAP);
  endfunction

  function automatic logic bad_request(logic [1:0] burst, logic [2:0] size,
                                       logic [2:0] full_size);
    return (burst == BURST_WRAP) || (size != full_size);
  endfunction

endpackage

// File: rtl/axi_mm_ram_2p.sv
// Word-wide RAM with one synchronous read port and one byte-enabled write port.
module axi_mm_ram_2p #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 12
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [DWIDTH/8-1:0] wr_strb
);

  localparam int unsigned BW    = DWIDTH / 8;
  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  // Array is deliberately not reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BW; i++) begin
        if (wr_strb[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axi_mm_mem_responder.sv
// AXI4 memory-mapped responder backed by an internal byte-enabled RAM.
// Optional AXI_MM_RESP_CHECK_EN flags WRAP/narrow requests and wlast count errors as SLVERR.
module axi_mm_mem_responder
  import axi_mm_mem_responder_pkg::*;
#(
  parameter int unsigned AXI_AWIDTH = 32,
  parameter int unsigned AXI_DWIDTH = 32,
  parameter int unsigned MEM_AWIDTH = 12
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [3:0]              arid,
  input  logic [AXI_AWIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  output logic [3:0]              rid,
  output logic [AXI_DWIDTH-1:0]   rdata,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    rlast,
  output logic [1:0]              rresp,
  input  logic [3:0]              awid,
  input  logic [AXI_AWIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic [3:0]              wid,
  input  logic [AXI_DWIDTH-1:0]   wdata,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic                    wlast,
  input  logic [AXI_DWIDTH/8-1:0] wstrb,
  output logic [3:0]              bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  localparam int unsigned BW  = AXI_DWIDTH / 8;
  localparam int unsigned LSB = $clog2(BW);

  logic ar_bad, aw_bad, unused_cfg;

`ifdef AXI_MM_RESP_CHECK_EN
  localparam logic [2:0] FULL_SIZE = 3'(LSB);
  assign ar_bad     = bad_request(arburst, arsize, FULL_SIZE);
  assign aw_bad     = bad_request(awburst, awsize, FULL_SIZE);
  assign unused_cfg = 1'b0;
`else
  assign ar_bad     = 1'b0;
  assign aw_bad     = 1'b0;
  assign unused_cfg = ^{arsize, awsize, awlen};
`endif

  logic unused_bits;
  assign unused_bits = ^{wid, unused_cfg,
                         araddr[AXI_AWIDTH-1:MEM_AWIDTH+LSB], araddr[LSB-1:0],
                         awaddr[AXI_AWIDTH-1:MEM_AWIDTH+LSB], awaddr[LSB-1:0]};

  // Read channel state
  rd_state_e             rd_state_q;
  logic                  arready_q, rvalid_q, rlast_q, rfixed_q, rerr_q;
  logic [3:0]            rid_q;
  logic [1:0]            rresp_q;
  logic [MEM_AWIDTH-1:0] raddr_q;
  logic [7:0]            rlen_q, rbeat_q;
  logic [AXI_DWIDTH-1:0] ram_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state_q <= RdIdle;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rresp_q    <= RESP_OKAY;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rbeat_q    <= '0;
      rfixed_q   <= 1'b0;
      rerr_q     <= 1'b0;
    end else begin
      unique case (rd_state_q)
        RdIdle: begin
          if (arvalid) begin
            rid_q      <= arid;
            raddr_q    <= araddr[MEM_AWIDTH+LSB-1:LSB];
            rlen_q     <= arlen;
            rbeat_q    <= '0;
            rfixed_q   <= !burst_advances(arburst);
            rerr_q     <= ar_bad;
            arready_q  <= 1'b0;
            rd_state_q <= RdFetch;
          end
        end
        RdFetch: begin
          rvalid_q   <= 1'b1;
          rlast_q    <= (rbeat_q == rlen_q);
          rresp_q    <= rerr_q ? RESP_SLVERR : RESP_OKAY;
          rd_state_q <= RdValid;
        end
        RdValid: begin
          if (rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) begin
              arready_q  <= 1'b1;
              rd_state_q <= RdIdle;
            end else begin
              rbeat_q    <= rbeat_q + 8'd1;
              if (!rfixed_q) raddr_q <= raddr_q + 1'b1;
              rd_state_q <= RdFetch;
            end
          end
        end
        default: rd_state_q <= RdIdle;
      endcase
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rresp   = rresp_q;
  assign rdata   = rerr_q ? '0 : ram_rdata;

  // Write channel state
  wr_state_e             wr_state_q;
  logic                  awready_q, wready_q, bvalid_q, wfixed_q, werr_q;
  logic [3:0]            bid_q;
  logic [1:0]            bresp_q;
  logic [MEM_AWIDTH-1:0] waddr_q;
`ifdef AXI_MM_RESP_CHECK_EN
  logic [7:0]            wlen_q;
  logic [8:0]            wcount_q;
`endif

  logic w_fire, ram_we;
  assign w_fire = (wr_state_q == WrData) && wvalid;
  assign ram_we = w_fire && !werr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_state_q <= WrIdle;
      awready_q  <= 1'b1;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
      waddr_q    <= '0;
      wfixed_q   <= 1'b0;
      werr_q     <= 1'b0;
`ifdef AXI_MM_RESP_CHECK_EN
      wlen_q     <= '0;
      wcount_q   <= '0;
`endif
    end else begin
      unique case (wr_state_q)
        WrIdle: begin
          if (awvalid) begin
            bid_q      <= awid;
            waddr_q    <= awaddr[MEM_AWIDTH+LSB-1:LSB];
            wfixed_q   <= !burst_advances(awburst);
            werr_q     <= aw_bad;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            wr_state_q <= WrData;
`ifdef AXI_MM_RESP_CHECK_EN
            wlen_q     <= awlen;
            wcount_q   <= '0;
`endif
          end
        end
        WrData: begin
          if (wvalid) begin
            if (!wfixed_q) waddr_q <= waddr_q + 1'b1;
`ifdef AXI_MM_RESP_CHECK_EN
            wcount_q <= wcount_q + 9'd1;
`endif
            // Only wlast closes the burst, however many beats arrived.
            if (wlast) begin
              wready_q   <= 1'b0;
              bvalid_q   <= 1'b1;
              wr_state_q <= WrResp;
`ifdef AXI_MM_RESP_CHECK_EN
              bresp_q <= (werr_q || (wcount_q != {1'b0, wlen_q})) ? RESP_SLVERR : RESP_OKAY;
`else
              bresp_q <= RESP_OKAY;
`endif
            end
          end
        end
        WrResp: begin
          if (bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wr_state_q <= WrIdle;
          end
        end
        default: wr_state_q <= WrIdle;
      endcase
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;

  axi_mm_ram_2p #(
    .DWIDTH(AXI_DWIDTH),
    .AWIDTH(MEM_AWIDTH)
  ) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .rd_en  (rd_state_q == RdFetch),
    .rd_addr(raddr_q),
    .rd_data(ram_rdata),
    .wr_en  (ram_we),
    .wr_addr(waddr_q),
    .wr_data(wdata),
    .wr_strb(wstrb)
  );

endmodule

// File: tb/tb_axi_mm_mem_responder.sv
// Self-checking bench for axi_mm_mem_responder against a word-array memory model.
module tb_axi_mm_mem_responder;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  axi_mm_mem_responder #(
    .AXI_AWIDTH(32),
    .AXI_DWIDTH(32),
    .MEM_AWIDTH(12)
  ) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wid(wid), .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast), .wstrb(wstrb),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] model_mem [4096];
  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  time b_time, r_done_time;

`ifdef AXI_MM_RESP_CHECK_EN
  localparam logic WRAP_ERR = 1'b1;
`else
  localparam logic WRAP_ERR = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    for (int k = 0; k < 4; k++) if (s[k]) model_mem[idx][8*k +: 8] = d[8*k +: 8];
  endtask

  task automatic wr_burst(input string tag, input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst);
    int n;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    if (!awready) begin check({tag, "_awready"}, 0, 1); awvalid = 1'b0; return; end
    tick();
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == int'(len)); wvalid = 1'b1;
      wid = $urandom_range(0, 15);
      n = 0;
      while (!wready && n < 50) begin tick(); n++; end
      if (!wready) begin check({tag, "_wready"}, 0, 1); wvalid = 1'b0; return; end
      tick();
      model_write((widx(addr) + ((burst == FIXED) ? 0 : b)) % 4096, wbuf[b], sbuf[b]);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    if (!bvalid) begin check({tag, "_bvalid"}, 0, 1); bready = 1'b0; return; end
    check({tag, "_bid"}, bid, id);
    check({tag, "_bresp"}, bresp, 2'b00);
    tick();
    bready = 1'b0;
    b_time = $time;
  endtask

  task automatic rd_burst(input string tag, input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst, input int stall_beat,
                          input logic err);
    int n;
    logic [31:0] exp_d, held_d;
    logic held_l;
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    if (!arready) begin check({tag, "_arready"}, 0, 1); arvalid = 1'b0; return; end
    tick();
    arvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      int idx;
      idx = (widx(addr) + ((burst == FIXED) ? 0 : b)) % 4096;
      exp_d = err ? 32'h0 : model_mem[idx];
      rready = (b != stall_beat);
      n = 0;
      while (!rvalid && n < 50) begin tick(); n++; end
      if (!rvalid) begin check({tag, "_rvalid"}, 0, 1); rready = 1'b0; return; end
      if (b == stall_beat) begin
        held_d = rdata; held_l = rlast;
        for (int c = 0; c < 5; c++) begin
          tick();
          check({tag, "_stall_rvalid"}, rvalid, 1);
          check({tag, "_stall_rdata"}, rdata, held_d);
          check({tag, "_stall_rlast"}, rlast, held_l);
        end
        rready = 1'b1;
      end
      check({tag, "_rdata"}, rdata, exp_d);
      check({tag, "_rlast"}, rlast, (b == int'(len)));
      check({tag, "_rid"}, rid, id);
      check({tag, "_rresp"}, rresp, err ? 2'b10 : 2'b00);
      tick();
    end
    rready = 1'b0;
    r_done_time = $time;
    check({tag, "_no_extra_beat"}, rvalid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    arid = '0; araddr = '0; arvalid = 1'b0; arlen = '0; arsize = 3'd2; arburst = INCR;
    rready = 1'b0;
    awid = '0; awaddr = '0; awvalid = 1'b0; awlen = '0; awsize = 3'd2; awburst = INCR;
    wid = '0; wdata = '0; wvalid = 1'b0; wlast = 1'b0; wstrb = '0; bready = 1'b0;
    b_time = 0; r_done_time = 0;
    repeat (3) tick();
    check("rst_arready", arready, 1);
    check("rst_awready", awready, 1);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_ids", {rid, bid}, 8'h00);
    check("rst_resps", {rresp, bresp}, 4'h0);
    check("rst_rdata", rdata, 32'h0);
    resetn = 1'b1;
    tick();
    check("rel_arready", arready, 1);
    check("rel_awready", awready, 1);

    // Basic INCR write then read-back
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + i; sbuf[i] = 4'hF; end
    wr_burst("wr_incr", 4'd5, 32'h100, 8'd3, INCR);
    rd_burst("rd_incr", 4'd9, 32'h100, 8'd3, INCR, -1, 1'b0);

    // Back-pressure on beat 2 (index 1)
    rd_burst("rd_stall", 4'd3, 32'h100, 8'd3, INCR, 1, 1'b0);

    // Partial strobe merge
    wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
    wr_burst("wr_full", 4'd1, 32'h200, 8'd0, INCR);
    wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'b0010;
    wr_burst("wr_strb", 4'd2, 32'h200, 8'd0, INCR);
    check("model_strb", model_mem[widx(32'h200)], 32'h1122FF44);
    rd_burst("rd_strb", 4'd4, 32'h200, 8'd0, INCR, -1, 1'b0);

    // FIXED read overlapped with an independent write
    wbuf[0] = $urandom; sbuf[0] = 4'hF;
    wr_burst("wr_fixed_src", 4'd6, 32'h20, 8'd0, INCR);
    wbuf[0] = $urandom; sbuf[0] = 4'hF;
    fork
      rd_burst("rd_fixed", 4'd7, 32'h20, 8'd2, FIXED, -1, 1'b0);
      begin
        tick();
        wr_burst("wr_concurrent", 4'd8, 32'h40, 8'd0, INCR);
      end
    join
    check("b_during_read", (b_time < r_done_time), 1);
    rd_burst("rd_concurrent", 4'd8, 32'h40, 8'd0, INCR, -1, 1'b0);

    // WRAP burst
    rd_burst("rd_wrap", 4'd10, 32'h100, 8'd3, WRAP, -1, WRAP_ERR);

    // Reset in the middle of both bursts
    araddr = 32'h100; arlen = 8'd3; arburst = INCR; arvalid = 1'b1; rready = 1'b0;
    awaddr = 32'h300; awlen = 8'd3; awburst = INCR; awvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0;
    repeat (3) tick();
    check("pre_rst_rvalid", rvalid, 1);
    check("pre_rst_wready", wready, 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_arready", arready, 1);
    check("mid_rst_awready", awready, 1);
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_wready", wready, 0);
    tick();
    resetn = 1'b1;
    tick();
    rd_burst("rd_after_rst", 4'd11, 32'h100, 8'd3, INCR, -1, 1'b0);

    // Randomized bursts, including upper-address aliasing and wrap past the last word
    for (int it = 0; it < 10; it++) begin
      logic [31:0] addr;
      logic [7:0]  len;
      logic [1:0]  burst;
      addr  = $urandom & 32'hFFFF_FFFC;
      if (it == 0) addr = 32'h0000_3FF8;
      len   = 8'($urandom_range(0, 7));
      burst = ($urandom_range(0, 1) == 1) ? INCR : FIXED;
      for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
      wr_burst("rand_wr_full", 4'($urandom_range(0, 15)), addr, len, burst);
      for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom); end
      wr_burst("rand_wr_strb", 4'($urandom_range(0, 15)), addr, len, burst);
      rd_burst("rand_rd", 4'($urandom_range(0, 15)), addr ^ 32'h8000_0000, len, burst,
               int'($urandom_range(0, 8)) - 1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
